xras_job_scheduler: RTL
=======================

# xras_job_scheduler

Sequencer and arbiter for the shared XRAS reliability pipeline. Up to NUM_REQ requesters (XRAD diagnostic lanes, XENOA tensor lanes, management SLA writers) post jobs. The block picks one job at a time and drives the pipeline's SLA-config or scoring entry. It waits for the pipeline's completion pulse, or a watchdog timeout, and retires the job back to its owner with a status. Only one job is ever in flight, so the pipeline's single-threaded state machine is never overrun.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 1024: cycles in WAIT before a job is aborted.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester job pending; held until granted or withdrawn
- req_kind  in  2*NUM_REQ  per-requester kind: 01 SLA_CFG, 10 SCORE, 00/11 invalid
- req_boundary  in  16*NUM_REQ  per-requester boundary_id
- req_ready  out  NUM_REQ  one-hot, one-cycle grant pulse
- done_valid  out  1  one-cycle retire pulse
- done_req  out  3  index of the retired requester
- done_status  out  2  00 OK, 01 TIMEOUT, 10 BADKIND
- core_ready  in  1  pipeline idle/ready
- core_sla_updated  in  1  SLA-config completion pulse
- core_packet_valid  in  1  scoring completion pulse (settlement packet ready)
- core_sla_cfg_valid  out  1  one-cycle SLA-config launch
- core_tensor_valid  out  1  one-cycle scoring launch
- core_boundary_id  out  16  boundary of the in-flight job; held from ISSUE through RETIRE
- core_abort  out  1  one-cycle pulse on timeout
- busy  out  1  high in any state other than IDLE
- grant_cnt  out  CNT_W  jobs granted, saturating
- timeout_cnt  out  CNT_W  jobs timed out, saturating

## Operation
- States: IDLE, ARB, ISSUE, WAIT, RETIRE.
- IDLE: if any req_valid is high, go to ARB. Otherwise stay.
- ARB, arbitration class priority:
  - SLA_CFG requests beat all others. SCORE and invalid kinds share the lower class.
  - Within a class, round-robin starting at rr_ptr+1 and wrapping modulo NUM_REQ.
  - If every request has dropped by the ARB cycle, return to IDLE with no grant.
- ARB, on a winner w:
  - Pulse req_ready[w].
  - Latch w, its kind and its boundary.
  - Set rr_ptr=w and increment grant_cnt.
  - Invalid kind: go to RETIRE with BADKIND; the core is untouched. Valid kind: go to ISSUE.
- ISSUE: wait for core_ready=1. In that cycle, pulse core_sla_cfg_valid (SLA_CFG) or core_tensor_valid (SCORE), clear the watchdog, and go to WAIT.
- WAIT: completion is core_sla_updated for SLA_CFG or core_packet_valid for SCORE. The wrong-kind pulse is ignored.
  - Completion: go to RETIRE with OK.
  - Watchdog reaches TIMEOUT_CYC-1 with no completion: pulse core_abort, increment timeout_cnt, go to RETIRE with TIMEOUT.
  - Completion and timeout in the same cycle: completion wins, status OK, no abort.
- RETIRE: done_valid=1 with done_req/done_status for one cycle, then go to IDLE.
- Completion pulses arriving in IDLE, ARB or ISSUE are ignored.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: state IDLE, rr_ptr=NUM_REQ-1 so requester 0 wins first, all outputs 0, counters 0.
- Request seen in IDLE at cycle t:
  - req_ready at t+1.
  - Launch at t+2 at the earliest, if core_ready is high.
  - Completion seen at cycle c gives done_valid at c+1.
  - Next grant no earlier than c+3.
- BADKIND job: req_ready at t+1, done_valid at t+2.
- Timeout: core_abort and the transition to RETIRE occur in the WAIT cycle where the watchdog equals TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after launch. done_valid follows in the next cycle.
- Asynchronous reset mid-job drops the job: no done_valid is produced, core outputs go low immediately, and rr_ptr resets.
- Requester rules:
  - req_valid may drop before grant. The job is then lost with no response.
  - The requester must not post a new job until done_valid for its index.
  - req_kind and req_boundary are sampled only in ARB.

## Structure
- Shared package xras_sched_pkg: kind enum (KIND_SLA_CFG=2'b01, KIND_SCORE=2'b10), status enum (ST_OK, ST_TIMEOUT, ST_BADKIND), state enum.
- Sub-module xras_rr_picker: combinational masked round-robin. Inputs are a request vector and a pointer; outputs are a one-hot grant and a found flag. It is instantiated twice, once per class.
- The watchdog counter is sized to $clog2(TIMEOUT_CYC).

## Test plan
- Basic SCORE: req 2, kind 10, boundary 0x00A5, core_ready=1 -> req_ready[2] at t+1, core_tensor_valid at t+2 with boundary 0x00A5. core_packet_valid 5 cycles later -> done_valid, done_req=2, OK, grant_cnt=1.
- Class priority: reqs 0 and 1 SCORE and req 3 SLA_CFG, all raised in the same cycle -> grant order 3, 0, 1.
- Round-robin: all four requesters re-post SCORE after each done -> grants 0,1,2,3,0; rr_ptr wraps 3->0.
- Timeout: TIMEOUT_CYC=16, no completion -> core_abort exactly 16 cycles after launch, done_status=TIMEOUT, timeout_cnt=1. Completion and timeout forced into the same cycle -> OK, no abort.
- Core stall and stray pulses:
  - core_ready held low 10 cycles -> stays in ISSUE and launches on the first ready cycle.
  - core_sla_updated during a SCORE job is ignored.
  - Invalid kind 11 -> BADKIND at t+2, no core launch.
- Reset mid-WAIT: rst_n pulsed low -> all outputs 0, no done_valid. Next request from requester 0 is granted first.

Source files
------------

// File: rtl/xras_job_scheduler_pkg.sv
// Shared types for the XRAS job scheduler: job kinds, retire status and FSM states.
package xras_sched_pkg;

  typedef enum logic [1:0] {
    KIND_INV_00  = 2'b00,
    KIND_SLA_CFG = 2'b01,
    KIND_SCORE   = 2'b10,
    KIND_INV_11  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BADKIND = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_RETIRE
  } state_e;

  function automatic logic kind_is_valid(kind_e k);
    return (k == KIND_SLA_CFG) || (k == KIND_SCORE);
  endfunction

endpackage

// File: rtl/xras_job_scheduler_if.sv
// Requester and pipeline-core signals of the XRAS job scheduler.
interface xras_job_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [2*NUM_REQ-1:0]  req_kind;
  logic [16*NUM_REQ-1:0] req_boundary;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  done_valid;
  logic [2:0]            done_req;
  logic [1:0]            done_status;
  logic                  core_ready;
  logic                  core_sla_updated;
  logic                  core_packet_valid;
  logic                  core_sla_cfg_valid;
  logic                  core_tensor_valid;
  logic [15:0]           core_boundary_id;
  logic                  core_abort;

  // Requesters and the pipeline core sit on the master side.
  modport master (
    output req_valid, req_kind, req_boundary,
    output core_ready, core_sla_updated, core_packet_valid,
    input  req_ready, done_valid, done_req, done_status,
    input  core_sla_cfg_valid, core_tensor_valid, core_boundary_id, core_abort
  );

  modport slave (
    input  req_valid, req_kind, req_boundary,
    input  core_ready, core_sla_updated, core_packet_valid,
    output req_ready, done_valid, done_req, done_status,
    output core_sla_cfg_valid, core_tensor_valid, core_boundary_id, core_abort
  );
endinterface

// File: rtl/xras_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module xras_rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             found
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xras_job_scheduler.sv
// Single-job-in-flight sequencer/arbiter feeding the shared XRAS reliability pipeline.
module xras_job_scheduler
  import xras_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xras_job_scheduler_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     grant_cnt,
  output logic [CNT_W-1:0]     timeout_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_e           state, state_n;
  status_e          cur_status, status_n;
  kind_e            cur_kind, win_kind;
  logic [PTR_W-1:0] rr_ptr, cur_idx, win_idx;
  logic [15:0]      cur_bnd, win_bnd;
  logic [WD_W-1:0]  wd;
  logic [NUM_REQ-1:0] sla_req, low_req, sla_grant, low_grant, win_grant;
  logic sla_found, low_found, win_found;
  logic grant_take, launch, abort, completion;

  // SLA_CFG forms the high class; SCORE and invalid kinds share the low class.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      sla_req[i] = bus.req_valid[i] && (bus.req_kind[2*i +: 2] == KIND_SLA_CFG);
    end
    low_req = bus.req_valid & ~sla_req;
  end

  xras_rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_sla (
    .req(sla_req), .ptr(rr_ptr), .grant(sla_grant), .found(sla_found)
  );

  xras_rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_low (
    .req(low_req), .ptr(rr_ptr), .grant(low_grant), .found(low_found)
  );

  always_comb begin
    win_grant = sla_found ? sla_grant : low_grant;
    win_found = sla_found | low_found;
    win_idx   = '0;
    win_kind  = KIND_INV_00;
    win_bnd   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        win_idx  = PTR_W'(i);
        win_kind = kind_e'(bus.req_kind[2*i +: 2]);
        win_bnd  = bus.req_boundary[16*i +: 16];
      end
    end
  end

  assign completion = (cur_kind == KIND_SLA_CFG) ? bus.core_sla_updated : bus.core_packet_valid;

  // Next-state and pulse outputs; every core/requester strobe is a one-cycle decode of state.
  always_comb begin
    state_n                = state;
    status_n               = cur_status;
    grant_take             = 1'b0;
    launch                 = 1'b0;
    abort                  = 1'b0;
    bus.req_ready          = '0;
    bus.done_valid         = 1'b0;
    bus.core_sla_cfg_valid = 1'b0;
    bus.core_tensor_valid  = 1'b0;
    case (state)
      S_IDLE: if (|bus.req_valid) state_n = S_ARB;
      S_ARB: begin
        if (win_found) begin
          grant_take    = 1'b1;
          bus.req_ready = win_grant;
          if (kind_is_valid(win_kind)) begin
            state_n = S_ISSUE;
          end else begin
            state_n  = S_RETIRE;
            status_n = ST_BADKIND;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.core_ready) begin
          launch                 = 1'b1;
          bus.core_sla_cfg_valid = (cur_kind == KIND_SLA_CFG);
          bus.core_tensor_valid  = (cur_kind == KIND_SCORE);
          state_n                = S_WAIT;
        end
      end
      S_WAIT: begin
        if (completion) begin
          state_n  = S_RETIRE;
          status_n = ST_OK;
        end else if (wd == WD_LAST) begin
          abort    = 1'b1;
          state_n  = S_RETIRE;
          status_n = ST_TIMEOUT;
        end
      end
      S_RETIRE: begin
        bus.done_valid = 1'b1;
        state_n        = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.core_abort       = abort;
  assign bus.core_boundary_id = cur_bnd;
  assign bus.done_req         = (state == S_RETIRE) ? 3'(cur_idx) : 3'd0;
  assign bus.done_status      = (state == S_RETIRE) ? cur_status : ST_OK;
  assign busy                 = (state != S_IDLE);

  // Job context, watchdog and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_status  <= ST_OK;
      cur_kind    <= KIND_INV_00;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      cur_idx     <= '0;
      cur_bnd     <= '0;
      wd          <= '0;
      grant_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      state      <= state_n;
      cur_status <= status_n;
      if (grant_take) begin
        rr_ptr   <= win_idx;
        cur_idx  <= win_idx;
        cur_kind <= win_kind;
        cur_bnd  <= win_bnd;
        if (grant_cnt != '1) grant_cnt <= grant_cnt + CNT_W'(1);
      end
      if (launch) begin
        wd <= '0;
      end else if (state == S_WAIT) begin
        wd <= wd + WD_W'(1);
      end
      if (abort && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

endmodule
